conv_inst_repeat: RTL and testbench

Parametrised instruction replay stage for the CONV instruction path. Accepts one instruction bundle of `IN` words × `IRW` bits on a valid/ready input. Re-issues it on a valid/ready output 1 to 2^CW times, with an iteration index on every beat. The repeat count comes from a field in the instruction, so one stage serves both single-shot and looped instructions. It has a registered output, back-to-back instruction hand-over with no bubble, and a synchronous flush.

---
 rtl/conv_inst_repeat.sv | 91 +++++++++
 tb/tb_conv_inst_repeat.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_inst_repeat.sv
// Instruction replay stage: latches one CONV instruction bundle and re-issues it
// 1..2^CW times with an iteration index, handing over to the next bundle without a bubble.
module conv_inst_repeat #(
    parameter int IRW = 30,
    parameter int IN  = 3,
    parameter int CW  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [IRW*IN-1:0] m_inst,
    input  logic              m_valid,
    output logic              m_ready,
    output logic [IRW*IN-1:0] s_inst,
    output logic [CW-1:0]     s_idx,
    output logic              s_first,
    output logic              s_last,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              busy
);

    localparam int BW = IRW * IN;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   hold_q, hold_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   rm1_q, rm1_d;

    logic            load;
    logic            accept;
    logic [CW-1:0]   eff_rm1;

    // A bundle without the loop-enable bit is always a single beat.
    assign eff_rm1 = m_inst[0] ? m_inst[CW:1] : '0;

    assign s_valid = (state_q == ISSUE);
    assign busy    = s_valid;
    assign s_inst  = hold_q;
    assign s_idx   = idx_q;
    assign s_last  = s_valid && (idx_q == rm1_q);
    assign s_first = s_valid && (idx_q == '0);

    // Acceptance only opens on the final beat, so s_ready reaches m_ready only then.
    assign m_ready = !flush && (!s_valid || (s_ready && s_last));
    assign load    = m_valid && m_ready;
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            rm1_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            rm1_q   <= rm1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        rm1_d   = rm1_q;

        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (load) begin
            state_d = ISSUE;
            hold_d  = m_inst;
            idx_d   = '0;
            rm1_d   = eff_rm1;
        end else if (accept && s_last) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (accept) begin
            // idx never reaches 2^CW-1 here because that value is always the last beat.
            idx_d   = idx_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_conv_inst_repeat.sv
// Directed self-checking bench for conv_inst_repeat: single-shot, looping with
// back-to-back hand-over, backpressure, maximum count, flush and mid-run reset.
module tb_conv_inst_repeat;

    localparam int IRW = 30;
    localparam int IN  = 3;
    localparam int CW  = 4;
    localparam int BW  = IRW * IN;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [BW-1:0] m_inst;
    logic          m_valid;
    logic          m_ready;
    logic [BW-1:0] s_inst;
    logic [CW-1:0] s_idx;
    logic          s_first;
    logic          s_last;
    logic          s_valid;
    logic          s_ready;
    logic          busy;

    int errors = 0;
    int checks = 0;

    conv_inst_repeat #(.IRW(IRW), .IN(IN), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .m_inst  (m_inst),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .s_inst  (s_inst),
        .s_idx   (s_idx),
        .s_first (s_first),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] make_inst(input logic le, input logic [CW-1:0] rm1,
                                                input logic [BW-CW-2:0] payload);
        return {payload, rm1, le};
    endfunction

    // Advance one clock; inputs are then driven at +1 and outputs sampled at +2.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; m_valid = 1'b0; m_inst = '0; s_ready = 1'b0;
        #12;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_valid: got %0b want 0", s_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (s_idx !== '0) begin errors++; $display("[TB] FAIL reset_s_idx: got %0d want 0", s_idx); end
        checks++; if (s_first !== 1'b0 || s_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_first_last: got %0b%0b want 00", s_first, s_last); end
        checks++; if (s_inst !== '0) begin errors++; $display("[TB] FAIL reset_s_inst: got %0h want 0", s_inst); end
        checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_m_ready: got %0b want 1", m_ready); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_shot();
        logic [BW-1:0] inst;
        inst = make_inst(1'b0, 4'd7, 85'hABC);
        m_inst = inst; m_valid = 1'b1; s_ready = 1'b1;
        #1;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_m_ready_idle: got %0b want 1", m_ready); end
        next_cycle();
        m_valid = 1'b0;
        #1;
        checks++; if (s_valid !== 1'b1 || s_idx !== 4'd0) begin errors++; $display("[TB] FAIL single_beat: got v=%0b idx=%0d want v=1 idx=0", s_valid, s_idx); end
        checks++; if (s_first !== 1'b1 || s_last !== 1'b1) begin errors++; $display("[TB] FAIL single_first_last: got %0b%0b want 11", s_first, s_last); end
        checks++; if (s_inst !== inst) begin errors++; $display("[TB] FAIL single_payload: got %0h want %0h", s_inst, inst); end
        checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_m_ready_last: got %0b want 1", m_ready); end
        next_cycle();
        #1;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_retire: got v=%0b want 0", s_valid); end
    endtask

    task automatic test_loop_back_to_back();
        logic [BW-1:0] inst1, inst2;
        inst1 = make_inst(1'b1, 4'd8, 85'h1111);
        inst2 = make_inst(1'b0, 4'd0, 85'h2222);
        m_inst = inst1; m_valid = 1'b1; s_ready = 1'b1;
        next_cycle();
        m_inst = inst2;
        for (int k = 0; k <= 8; k++) begin
            #1;
            checks++; if (s_valid !== 1'b1 || s_idx !== CW'(k)) begin errors++; $display("[TB] FAIL loop_idx_%0d: got v=%0b idx=%0d want v=1 idx=%0d", k, s_valid, s_idx, k); end
            checks++; if (s_last !== (k == 8) || s_first !== (k == 0)) begin errors++; $display("[TB] FAIL loop_flags_%0d: got first=%0b last=%0b want %0b %0b", k, s_first, s_last, k == 0, k == 8); end
            checks++; if (m_ready !== (k == 8)) begin errors++; $display("[TB] FAIL loop_m_ready_%0d: got %0b want %0b", k, m_ready, k == 8); end
            checks++; if (s_inst !== inst1) begin errors++; $display("[TB] FAIL loop_inst_%0d: got %0h want %0h", k, s_inst, inst1); end
            next_cycle();
        end
        m_valid = 1'b0;
        #1;
        checks++; if (s_valid !== 1'b1 || s_idx !== 4'd0 || s_inst !== inst2) begin errors++; $display("[TB] FAIL b2b_handover: got v=%0b idx=%0d inst=%0h want v=1 idx=0 inst=%0h", s_valid, s_idx, s_inst, inst2); end
        next_cycle();
        #1;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_retire: got v=%0b want 0", s_valid); end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] inst;
        logic [6:0]    pattern;
        int            exp_idx;
        int            accepts;
        inst = make_inst(1'b1, 4'd3, 85'h3C3C);
        pattern = 7'b1011001;
        exp_idx = 0; accepts = 0;
        m_inst = inst; m_valid = 1'b1; s_ready = 1'b0;
        next_cycle();
        m_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_ready = pattern[6-i];
            #1;
            checks++; if (s_valid !== 1'b1 || s_idx !== CW'(exp_idx) || s_inst !== inst) begin errors++; $display("[TB] FAIL bp_cycle_%0d: got v=%0b idx=%0d want v=1 idx=%0d", i, s_valid, s_idx, exp_idx); end
            checks++; if (s_last !== (exp_idx == 3)) begin errors++; $display("[TB] FAIL bp_last_%0d: got %0b want %0b", i, s_last, exp_idx == 3); end
            if (s_ready && s_valid) begin
                accepts++;
                exp_idx++;
            end
            next_cycle();
        end
        s_ready = 1'b1;
        #1;
        checks++; if (accepts != 4) begin errors++; $display("[TB] FAIL bp_accepts: got %0d want 4", accepts); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle: got v=%0b want 0", s_valid); end
    endtask

    task automatic test_max_count();
        logic [BW-1:0] inst;
        inst = make_inst(1'b1, 4'd15, 85'h5A5A);
        m_inst = inst; m_valid = 1'b1; s_ready = 1'b1;
        next_cycle();
        m_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++; if (s_valid !== 1'b1 || s_idx !== CW'(k) || s_last !== (k == 15)) begin errors++; $display("[TB] FAIL max_beat_%0d: got v=%0b idx=%0d last=%0b want v=1 idx=%0d last=%0b", k, s_valid, s_idx, s_last, k, k == 15); end
            next_cycle();
        end
        #1;
        checks++; if (s_valid !== 1'b0 || s_idx !== 4'd0) begin errors++; $display("[TB] FAIL max_idle: got v=%0b idx=%0d want v=0 idx=0", s_valid, s_idx); end
    endtask

    task automatic test_flush();
        logic [BW-1:0] inst1, inst2;
        inst1 = make_inst(1'b1, 4'd8, 85'h7777);
        inst2 = make_inst(1'b0, 4'd0, 85'h8888);
        m_inst = inst1; m_valid = 1'b1; s_ready = 1'b1;
        next_cycle();
        m_valid = 1'b0;
        for (int k = 0; k < 3; k++) next_cycle();
        m_inst = inst2; m_valid = 1'b1; flush = 1'b1;
        #1;
        checks++; if (s_idx !== 4'd3) begin errors++; $display("[TB] FAIL flush_at_idx: got %0d want 3", s_idx); end
        checks++; if (m_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_m_ready: got %0b want 0", m_ready); end
        next_cycle();
        flush = 1'b0;
        #1;
        checks++; if (s_valid !== 1'b0 || s_idx !== 4'd0) begin errors++; $display("[TB] FAIL flush_idle: got v=%0b idx=%0d want v=0 idx=0", s_valid, s_idx); end
        checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_reopen: got %0b want 1", m_ready); end
        next_cycle();
        m_valid = 1'b0;
        #1;
        checks++; if (s_valid !== 1'b1 || s_idx !== 4'd0 || s_inst !== inst2) begin errors++; $display("[TB] FAIL flush_reload: got v=%0b idx=%0d inst=%0h want v=1 idx=0 inst=%0h", s_valid, s_idx, s_inst, inst2); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] inst;
        inst = make_inst(1'b1, 4'd8, 85'h9999);
        m_inst = inst; m_valid = 1'b1; s_ready = 1'b1;
        next_cycle();
        m_valid = 1'b0;
        for (int k = 0; k < 5; k++) next_cycle();
        #1;
        checks++; if (s_idx !== 4'd5) begin errors++; $display("[TB] FAIL rstmid_at_idx: got %0d want 5", s_idx); end
        rst_n = 1'b0;
        #1;
        checks++; if (s_valid !== 1'b0 || s_idx !== 4'd0) begin errors++; $display("[TB] FAIL rstmid_async: got v=%0b idx=%0d want v=0 idx=0", s_valid, s_idx); end
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_m_ready: got %0b want 1", m_ready); end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            #1;
            checks++; if (s_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stale_%0d: got v=%0b want 0", k, s_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_loop_back_to_back();
        test_backpressure();
        test_max_count();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
